// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and responder state type.
package spi_pkg;
  localparam int SPI_FRAME_W = 16;
  // bit counter must reach SPI_FRAME_W itself, hence the +1
  localparam int SPI_CNT_W   = $clog2(SPI_FRAME_W + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;
endpackage

// File: rtl/spi_serf_if.sv
// rtl/spi_serf_if.sv - SPI pins plus parallel tx/rx side of the SPI responder.
interface spi_serf_if;
  import spi_pkg::*;

  logic                   SS_n;
  logic                   SCLK;
  logic                   MOSI;
  logic                   MISO;
  logic [SPI_FRAME_W-1:0] tx_data;
  logic                   tx_ld;
  logic [SPI_FRAME_W-1:0] rx_data;
  logic                   rx_rdy;
  logic                   clr_rdy;
  logic                   frm_err;

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, tx_ld, clr_rdy,
    output MISO, rx_data, rx_rdy, frm_err
  );

  modport master (
    output SS_n, SCLK, MOSI, tx_data, tx_ld, clr_rdy,
    input  MISO, rx_data, rx_rdy, frm_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer plus history flop with rise/fall strobes.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta1, meta2, hist;

  // flops reset high so an idle-high line never produces a spurious edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta1 <= 1'b1;
      meta2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      meta1 <= async_in;
      meta2 <= meta1;
      hist  <= meta2;
    end
  end

  assign level = meta2;
  assign rise  = meta2 & ~hist;
  assign fall  = ~meta2 & hist;
endmodule

// File: rtl/spi_serf.sv
// rtl/spi_serf.sv - 16-bit SPI responder; SPI_SERF_FRAME_CHK_EN enables frame-length error checking.
module spi_serf
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  spi_serf_if.slave   bus
);
  localparam logic [SPI_CNT_W-1:0] CNT_FULL = SPI_CNT_W'(SPI_FRAME_W);

  state_t                 state, nxt_state;
  logic [SPI_FRAME_W-1:0] shift_reg, hold_reg, rx_data_q;
  logic [SPI_CNT_W-1:0]   bit_cnt;
  logic                   mosi_smpl, rx_rdy_q;
  logic                   mosi_m1, mosi_s;
  logic                   ss_lvl, ss_rise, ss_fall;
  logic                   sclk_lvl, sclk_rise, sclk_fall;
  logic                   unused_lvl;

  spi_sync_edge u_ss_sync (
    .clk(clk), .rst_n(rst_n), .async_in(bus.SS_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .async_in(bus.SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  assign unused_lvl = &{1'b0, ss_lvl, sclk_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_m1 <= 1'b1;
      mosi_s  <= 1'b1;
    end else begin
      mosi_m1 <= bus.MOSI;
      mosi_s  <= mosi_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (ss_fall) nxt_state = ACTIVE;
      ACTIVE:  if (ss_rise) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
      bit_cnt   <= '0;
      mosi_smpl <= 1'b0;
    end else begin
      // loading while idle also refreshes the shifter so MISO shows the new MSB
      if (bus.tx_ld) begin
        hold_reg <= bus.tx_data;
        if (state == IDLE) shift_reg <= bus.tx_data;
      end
      if (bus.clr_rdy) rx_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            shift_reg <= hold_reg;
            bit_cnt   <= '0;
            rx_rdy_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            mosi_smpl <= mosi_s;
            if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 1'b1;
          end
          // the select-edge fall has no preceding rise, so bit_cnt==0 skips it
          if (sclk_fall && bit_cnt != '0)
            shift_reg <= {shift_reg[SPI_FRAME_W-2:0], mosi_smpl};
          if (ss_rise && bit_cnt == CNT_FULL) begin
            rx_data_q <= {shift_reg[SPI_FRAME_W-2:0], mosi_smpl};
            rx_rdy_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SERF_FRAME_CHK_EN
  logic frm_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
    end else if (state == ACTIVE &&
                 ((ss_rise && bit_cnt != CNT_FULL) || (sclk_rise && bit_cnt == CNT_FULL))) begin
      frm_err_q <= 1'b1;
    end else if ((state == IDLE && ss_fall) || bus.clr_rdy) begin
      frm_err_q <= 1'b0;
    end
  end

  assign bus.frm_err = frm_err_q;
`else
  assign bus.frm_err = 1'b0;
`endif

  assign bus.MISO    = shift_reg[SPI_FRAME_W-1];
  assign bus.rx_data = rx_data_q;
  assign bus.rx_rdy  = rx_rdy_q;
endmodule

// File: doc/spi_serf.md
# spi_serf

SPI responder (serf) terminating the 16-bit SPI links driven by the team's SPI main. It synchronizes SS_n, SCLK and MOSI into the `clk` domain and detects SCLK edges. It shifts the main's command in and shifts a preloaded response word out on MISO. Each complete frame is presented as a parallel word with a ready flag. It sits inside sensor/peripheral models and on-chip peripheral front ends.

## Interface
- Parameters: none (frame width fixed at 16).
- clk  in  1  system clock; everything is sampled on its rising edge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  select from main, active low, asynchronous to `clk`
- SCLK  in  1  serial clock from main, idles high, asynchronous to `clk`
- MOSI  in  1  serial data from main, MSB first
- MISO  out  1  serial data to main, MSB first
- tx_data  in  16  response word for the next frame
- tx_ld  in  1  one-cycle strobe; writes `tx_data` into the holding register
- rx_data  out  16  last complete command received
- rx_rdy  out  1  set when a complete 16-bit frame has been received
- clr_rdy  in  1  one-cycle strobe; clears `rx_rdy`
- frm_err  out  1  frame-length error flag (see Configuration)

## Operation
- Synchronization:
  - SS_n and SCLK each pass through 2 meta flops plus 1 history flop, giving edge detect.
  - MOSI passes through 2 meta flops.
- State machine `state_t` = {IDLE, ACTIVE}:
  - IDLE -> ACTIVE on a synchronized SS_n fall. On that cycle: shift register <= holding register, bit_cnt <= 0, `rx_rdy` <= 0.
  - ACTIVE -> IDLE on a synchronized SS_n rise.
- Holding register: written by `tx_ld` in any state. A write during ACTIVE takes effect on the next frame only.
- Shift behaviour in ACTIVE:
  - SCLK rise: `mosi_smpl` <= synchronized MOSI; bit_cnt++ (saturates at 16).
  - SCLK fall with bit_cnt != 0: shift register <= {shift[14:0], mosi_smpl}.
  - The first fall after select has no preceding rise and is ignored.
- MISO = shift[15] at all times. In IDLE this is the holding-register MSB once loaded, otherwise the stale shift register.
- SS_n rise with bit_cnt == 16:
  - `rx_data` <= {shift[14:0], mosi_smpl}.
  - `rx_rdy` <= 1.
- SS_n rise with bit_cnt != 16: `rx_data` and `rx_rdy` unchanged; the frame is discarded.
- `clr_rdy` clears `rx_rdy`. If `clr_rdy` and a completing SS_n rise land in the same cycle, set wins.
- SCLK edges while in IDLE are ignored.
- SS_n fall and SS_n rise are never detected in the same cycle; the synchronizer guarantees this.
- Reset values:
  - shift register, holding register, `rx_data`: 0x0000
  - `rx_rdy`, `frm_err`, bit_cnt: 0
  - state: IDLE
  - synchronizer flops: 1
  - MISO: 0
- Reset asserted mid-frame aborts the frame. The bench must re-select before the next frame.

## Timing
- Edge-detect latency is 3 clk from pin change to internal strobe, for both SS_n and SCLK.
- MISO updates 3–4 clk after a SCLK fall.
- The main samples 24 clk after a fall, so MISO must be stable by then.
- `rx_rdy` and `rx_data` become valid 4 clk after the SS_n pin rises.
- Minimum SCLK half-period is 4 clk. Minimum SS_n fall to first SCLK fall is 4 clk.
- Back-to-back frames need SS_n high for at least 4 clk.

## Configuration
- `SPI_SERF_FRAME_CHK_EN` defined:
  - `frm_err` <= 1 on an SS_n rise with bit_cnt != 16.
  - `frm_err` <= 1 on a SCLK rise when bit_cnt is already 16 (overrun).
  - `frm_err` clears on the next SS_n fall or on `clr_rdy`.
- Not defined: `frm_err` is tied to 0 and no check logic is built.

## Structure
- `spi_pkg` holds:
  - `SPI_FRAME_W` = 16
  - `state_t`
  - the bit_cnt width constant, shared with the SPI main.
- Sub-module `spi_sync_edge` provides a 3-flop synchronizer with `rise`/`fall` strobes and a synchronized level output. It is instantiated for SS_n and SCLK.

## Test plan
- Preload `tx_data`=0xA5C3 via `tx_ld`, then the main sends 0x1234:
  - `rx_data`=0x1234 and `rx_rdy`=1.
  - The main's `resp`=0xA5C3.
- Back-to-back frames 0xFFFF then 0x0001 with `tx_ld`=0x8000 during frame 1:
  - Frame 2 returns 0x8000 on MISO.
  - `rx_data` ends at 0x0001.
- Abort by raising SS_n after 9 SCLK rises:
  - `rx_data` and `rx_rdy` unchanged.
  - With the macro: `frm_err`=1, cleared by the next SS_n fall.
- `clr_rdy` pulsed in the same cycle as a completing SS_n rise: `rx_rdy`=1.
- SCLK toggled 5 times with SS_n high: shift register and bit_cnt unchanged; MISO stable.
- `rst_n` pulsed low after 8 bits of frame 0x00FF:
  - All outputs return to reset values.
  - A following full frame 0xBEEF yields `rx_data`=0xBEEF.
